// File: rtl/vram_request_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module  : vram_request_scheduler_if
//  Brief   : Request/response bundle between the scheduler and the VRAM
//            memory controller (strobes, address/data out; data/busy back).
//  Rev     : 1.0
// ============================================================================
interface vram_request_scheduler_if;
    logic        mc_read;
    logic        mc_write;
    logic        mc_refresh;
    logic [21:0] mc_addr;
    logic [15:0] mc_din;
    logic [1:0]  mc_wdm;
    logic [15:0] mc_dout;
    logic        mc_busy;

    modport master (
        output mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
        input  mc_dout, mc_busy
    );

    modport slave (
        input  mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm,
        output mc_dout, mc_busy
    );
endinterface
`default_nettype wire

// File: rtl/vram_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : vram_request_scheduler
//  Brief   : Arbitrates display fetch, CPU and auto-refresh onto one VRAM
//            controller port and returns read data to the requesting client.
//  Rev     : 1.0
// ============================================================================
module vram_request_scheduler #(
    parameter int FREQ           = 54_000_000,
    parameter int REFRESH_CYCLES = 420,
    parameter int STARVE_LIMIT   = 4
) (
    input  wire         clk,
    input  wire         resetn,

    input  wire         disp_req,
    input  wire  [21:0] disp_addr,
    output logic        disp_ack,
    output logic [15:0] disp_data,
    output logic        disp_valid,

    input  wire         cpu_req,
    input  wire         cpu_we,
    input  wire  [21:0] cpu_addr,
    input  wire  [15:0] cpu_din,
    input  wire  [1:0]  cpu_wdm,
    output logic        cpu_ack,
    output logic [15:0] cpu_dout,
    output logic        cpu_valid,

    vram_request_scheduler_if.master mc,

    output logic        refresh_overrun
);

    localparam int c_TIMER_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int c_STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_TIMER_W-1:0]  c_TIMER_MAX  = c_TIMER_W'(REFRESH_CYCLES - 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    localparam logic [1:0] c_OP_DISP_RD = 2'd0;
    localparam logic [1:0] c_OP_CPU_RD  = 2'd1;
    localparam logic [1:0] c_OP_CPU_WR  = 2'd2;
    localparam logic [1:0] c_OP_REFRESH = 2'd3;

    // FREQ only records the clock that REFRESH_CYCLES was derived for.
    if (FREQ <= 0) begin : g_freq_unspecified
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_op;
    logic                   r_wait_cnt;
    logic                   r_retried;
    logic [c_TIMER_W-1:0]   r_refresh_timer;
    logic [1:0]             r_refresh_pend;
    logic [c_STARVE_W-1:0]  r_starve_cnt;
    logic                   r_refresh_overrun;

    logic                   r_mc_read;
    logic                   r_mc_write;
    logic                   r_mc_refresh;
    logic [21:0]            r_mc_addr;
    logic [15:0]            r_mc_din;
    logic [1:0]             r_mc_wdm;
    logic [15:0]            r_disp_data;
    logic                   r_disp_valid;
    logic [15:0]            r_cpu_dout;
    logic                   r_cpu_valid;

    logic                   w_can_grant;
    logic                   w_gnt_refresh;
    logic                   w_gnt_cpu;
    logic                   w_gnt_disp;
    logic                   w_tick;

    assign w_tick      = (r_refresh_timer == c_TIMER_MAX);
    // resetn is included so the acks read 0 while reset is held.
    assign w_can_grant = resetn && (r_state == S_IDLE) && !mc.mc_busy;

    always_comb begin
        w_gnt_refresh = 1'b0;
        w_gnt_cpu     = 1'b0;
        w_gnt_disp    = 1'b0;
        if (w_can_grant) begin
            if (r_refresh_pend != 2'd0)
                w_gnt_refresh = 1'b1;
            else if (cpu_req && (r_starve_cnt == c_STARVE_MAX))
                w_gnt_cpu = 1'b1;
            else if (disp_req)
                w_gnt_disp = 1'b1;
            else if (cpu_req)
                w_gnt_cpu = 1'b1;
        end
    end

    assign disp_ack        = w_gnt_disp;
    assign cpu_ack         = w_gnt_cpu;
    assign disp_data       = r_disp_data;
    assign disp_valid      = r_disp_valid;
    assign cpu_dout        = r_cpu_dout;
    assign cpu_valid       = r_cpu_valid;
    assign refresh_overrun = r_refresh_overrun;

    assign mc.mc_read    = r_mc_read;
    assign mc.mc_write   = r_mc_write;
    assign mc.mc_refresh = r_mc_refresh;
    assign mc.mc_addr    = r_mc_addr;
    assign mc.mc_din     = r_mc_din;
    assign mc.mc_wdm     = r_mc_wdm;

    // Free-running refresh timer and saturating pending-refresh count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_refresh_timer   <= '0;
            r_refresh_pend    <= 2'd0;
            r_refresh_overrun <= 1'b0;
        end else begin
            if (w_tick)
                r_refresh_timer <= '0;
            else
                r_refresh_timer <= r_refresh_timer + c_TIMER_W'(1);

            if (w_tick && !w_gnt_refresh) begin
                if (r_refresh_pend == 2'd3)
                    r_refresh_overrun <= 1'b1;
                else
                    r_refresh_pend <= r_refresh_pend + 2'd1;
            end else if (!w_tick && w_gnt_refresh) begin
                r_refresh_pend <= r_refresh_pend - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (!cpu_req || w_gnt_cpu) begin
            r_starve_cnt <= '0;
        end else if (w_gnt_disp && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_op         <= c_OP_DISP_RD;
            r_wait_cnt   <= 1'b0;
            r_retried    <= 1'b0;
            r_mc_read    <= 1'b0;
            r_mc_write   <= 1'b0;
            r_mc_refresh <= 1'b0;
            r_mc_addr    <= '0;
            r_mc_din     <= '0;
            r_mc_wdm     <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_cpu_dout   <= '0;
            r_cpu_valid  <= 1'b0;
        end else begin
            r_mc_read    <= 1'b0;
            r_mc_write   <= 1'b0;
            r_mc_refresh <= 1'b0;
            r_disp_valid <= 1'b0;
            r_cpu_valid  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_retried <= 1'b0;
                    if (w_gnt_refresh) begin
                        r_mc_refresh <= 1'b1;
                        r_op         <= c_OP_REFRESH;
                        r_state      <= S_ISSUE;
                    end else if (w_gnt_disp) begin
                        r_mc_read <= 1'b1;
                        r_mc_addr <= disp_addr;
                        r_mc_din  <= '0;
                        r_mc_wdm  <= '0;
                        r_op      <= c_OP_DISP_RD;
                        r_state   <= S_ISSUE;
                    end else if (w_gnt_cpu) begin
                        r_mc_read  <= !cpu_we;
                        r_mc_write <= cpu_we;
                        r_mc_addr  <= cpu_addr;
                        r_mc_din   <= cpu_din;
                        r_mc_wdm   <= cpu_wdm;
                        r_op       <= cpu_we ? c_OP_CPU_WR : c_OP_CPU_RD;
                        r_state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_wait_cnt <= 1'b0;
                    r_state    <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY: begin
                    if (mc.mc_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_wait_cnt && !r_retried) begin
                        // Controller never went busy: replay the same strobe once.
                        r_retried    <= 1'b1;
                        r_mc_read    <= (r_op == c_OP_DISP_RD) || (r_op == c_OP_CPU_RD);
                        r_mc_write   <= (r_op == c_OP_CPU_WR);
                        r_mc_refresh <= (r_op == c_OP_REFRESH);
                        r_state      <= S_ISSUE;
                    end else begin
                        r_wait_cnt <= 1'b1;
                    end
                end

                S_WAIT_DONE: begin
                    if (!mc.mc_busy) begin
                        if (r_op == c_OP_DISP_RD) begin
                            r_disp_data  <= mc.mc_dout;
                            r_disp_valid <= 1'b1;
                        end else if (r_op == c_OP_CPU_RD) begin
                            r_cpu_dout  <= mc.mc_dout;
                            r_cpu_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_vram_request_scheduler
//  Brief   : Directed self-checking bench with a simple VRAM controller model.
//  Rev     : 1.0
// ============================================================================
module tb_vram_request_scheduler;

    localparam int c_BUSY_LEN = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        disp_req;
    logic [21:0] disp_addr;
    logic        disp_ack;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [21:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_wdm;
    logic        cpu_ack;
    logic [15:0] cpu_dout;
    logic        cpu_valid;
    logic        refresh_overrun;

    vram_request_scheduler_if mc_if ();

    vram_request_scheduler u_dut (
        .clk             (clk),
        .resetn          (resetn),
        .disp_req        (disp_req),
        .disp_addr       (disp_addr),
        .disp_ack        (disp_ack),
        .disp_data       (disp_data),
        .disp_valid      (disp_valid),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_wdm         (cpu_wdm),
        .cpu_ack         (cpu_ack),
        .cpu_dout        (cpu_dout),
        .cpu_valid       (cpu_valid),
        .mc              (mc_if),
        .refresh_overrun (refresh_overrun)
    );

    always #5 clk = ~clk;

    // Controller model: busy for c_BUSY_LEN cycles per accepted strobe.
    int          busy_cnt    = 0;
    logic        force_busy  = 1'b1;
    logic        ignore_next = 1'b0;
    logic [15:0] rd_value    = 16'h0000;

    assign mc_if.mc_busy = force_busy || (busy_cnt != 0);

    initial begin
        mc_if.mc_dout = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if ((mc_if.mc_read || mc_if.mc_write || mc_if.mc_refresh) && ignore_next) begin
                ignore_next = 1'b0;
            end else if (mc_if.mc_read || mc_if.mc_write || mc_if.mc_refresh) begin
                busy_cnt = c_BUSY_LEN;
                if (mc_if.mc_read)
                    mc_if.mc_dout = rd_value;
            end else if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    int          cyc = 0;
    int          n_read = 0, n_write = 0, n_ref = 0;
    int          n_dack = 0, n_cack = 0, n_dval = 0, n_cval = 0;
    int          n_back2back = 0;
    int          t_dack = 0, t_read = 0, n_ref_at_dack = 0;
    logic        prev_strobe = 1'b0;
    logic        mon_strobe;
    logic [21:0] last_addr = '0;
    logic [15:0] last_din  = '0;
    logic [1:0]  last_wdm  = '0;
    byte         glog[$];

    always @(negedge clk) begin
        cyc++;
        mon_strobe = mc_if.mc_read || mc_if.mc_write || mc_if.mc_refresh;
        if (mon_strobe && prev_strobe) n_back2back++;
        prev_strobe = mon_strobe;
        if (mon_strobe) begin
            last_addr = mc_if.mc_addr;
            last_din  = mc_if.mc_din;
            last_wdm  = mc_if.mc_wdm;
        end
        if (mc_if.mc_read)    begin n_read++; t_read = cyc; end
        if (mc_if.mc_write)   n_write++;
        if (mc_if.mc_refresh) n_ref++;
        if (disp_ack) begin n_dack++; t_dack = cyc; n_ref_at_dack = n_ref; glog.push_back("D"); end
        if (cpu_ack)  begin n_cack++; glog.push_back("C"); end
        if (disp_valid) n_dval++;
        if (cpu_valid)  n_cval++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic disp_request(input logic [21:0] a);
        logic got;
        got       = 1'b0;
        disp_addr = a;
        disp_req  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (disp_ack) begin
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        disp_req  = 1'b0;
        disp_addr = ~a;
        check_eq("disp_ack_seen", got, 1);
    endtask

    task automatic cpu_request(input logic we, input logic [21:0] a,
                               input logic [15:0] d, input logic [1:0] m);
        logic got;
        got      = 1'b0;
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
        cpu_wdm  = m;
        cpu_req  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (cpu_ack) begin
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        cpu_req  = 1'b0;
        cpu_addr = ~a;
        cpu_din  = ~d;
        cpu_wdm  = ~m;
        check_eq("cpu_ack_seen", got, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int    s_read, s_write, s_ref, s_dack, s_cack, s_dval, s_cval;
    string seq;

    task automatic snap();
        s_read = n_read; s_write = n_write; s_ref = n_ref;
        s_dack = n_dack; s_cack = n_cack; s_dval = n_dval; s_cval = n_cval;
    endtask

    initial begin
        resetn    = 1'b0;
        disp_req  = 1'b1;
        disp_addr = 22'h0ABCDE;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;
        cpu_wdm   = '0;
        tick(3);

        // Reset state
        check_eq("rst_flags", {mc_if.mc_read, mc_if.mc_write, mc_if.mc_refresh, disp_ack,
                               cpu_ack, disp_valid, cpu_valid, refresh_overrun}, 0);
        check_eq("rst_mc_addr", mc_if.mc_addr, 0);
        check_eq("rst_mc_din_wdm", {mc_if.mc_din, mc_if.mc_wdm}, 0);
        check_eq("rst_rdata", {disp_data, cpu_dout}, 0);

        // Controller init: no strobe while busy
        resetn = 1'b1;
        tick(100);
        check_eq("init_no_strobe", n_read + n_write + n_ref, 0);
        check_eq("init_no_ack", n_dack, 0);
        force_busy = 1'b0;
        disp_request(22'h0ABCDE);
        tick(20);
        check_eq("init_strobe_latency", t_read - t_dack, 1);
        check_eq("init_read_addr", last_addr, 22'h0ABCDE);
        check_eq("init_dack_once", n_dack, 1);
        check_eq("init_read_once", n_read, 1);

        // Display read returning 0xBEEF
        rd_value = 16'hBEEF;
        snap();
        disp_request(22'h000123);
        tick(20);
        check_eq("drd_data", disp_data, 16'hBEEF);
        check_eq("drd_valid_cnt", n_dval - s_dval, 1);
        check_eq("drd_no_cpu_valid", n_cval - s_cval, 0);
        check_eq("drd_addr", last_addr, 22'h000123);

        // CPU read; display data must hold
        rd_value = 16'hC0DE;
        snap();
        cpu_request(1'b0, 22'h155555, 16'hFFFF, 2'b11);
        tick(20);
        check_eq("crd_data", cpu_dout, 16'hC0DE);
        check_eq("crd_valid_cnt", n_cval - s_cval, 1);
        check_eq("crd_disp_hold", disp_data, 16'hBEEF);
        check_eq("crd_no_disp_valid", n_dval - s_dval, 0);

        // CPU write at top address
        snap();
        cpu_request(1'b1, 22'h3FFFFF, 16'h1234, 2'b01);
        tick(20);
        check_eq("cwr_write_cnt", n_write - s_write, 1);
        check_eq("cwr_no_read", n_read - s_read, 0);
        check_eq("cwr_addr", last_addr, 22'h3FFFFF);
        check_eq("cwr_din", last_din, 16'h1234);
        check_eq("cwr_wdm", last_wdm, 2'b01);
        check_eq("cwr_ack_cnt", n_cack - s_cack, 1);
        check_eq("cwr_no_cpu_valid", n_cval - s_cval, 0);

        // Missed strobe is replayed once
        ignore_next = 1'b1;
        rd_value    = 16'h7E57;
        snap();
        disp_request(22'h000456);
        tick(25);
        check_eq("miss_read_cnt", n_read - s_read, 2);
        check_eq("miss_valid_cnt", n_dval - s_dval, 1);
        check_eq("miss_data", disp_data, 16'h7E57);

        // Starvation guard with both clients held
        glog.delete();
        disp_addr = 22'h000010;
        cpu_we    = 1'b0;
        cpu_addr  = 22'h000020;
        disp_req  = 1'b1;
        cpu_req   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (glog.size() >= 10) break;
            tick();
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        tick(20);
        seq = "DDDDCDDDDC";
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("starve_seq[%0d]", i), (i < glog.size()) ? glog[i] : 8'h00, seq[i]);
        end
        check_eq("strobe_spacing", n_back2back, 0);

        // Refresh backlog while controller busy
        resetn     = 1'b0;
        force_busy = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(1300);
        check_eq("ovr_after_3_ticks", refresh_overrun, 0);
        tick(420);
        check_eq("ovr_after_4_ticks", refresh_overrun, 1);
        snap();
        rd_value   = 16'hA11A;
        force_busy = 1'b0;
        disp_request(22'h000077);
        check_eq("ref_before_grant", n_ref_at_dack - s_ref, 3);
        tick(20);
        check_eq("ref_total", n_ref - s_ref, 3);
        check_eq("ovr_sticky", refresh_overrun, 1);
        check_eq("ref_then_read", disp_data, 16'hA11A);

        // Asynchronous reset during WAIT_DONE
        rd_value = 16'h5A5A;
        snap();
        disp_request(22'h0000AB);
        tick(2);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("arst_flags", {mc_if.mc_read, mc_if.mc_write, mc_if.mc_refresh, disp_ack,
                                cpu_ack, disp_valid, cpu_valid, refresh_overrun}, 0);
        check_eq("arst_mc_addr", mc_if.mc_addr, 0);
        check_eq("arst_rdata", {disp_data, cpu_dout}, 0);
        tick(2);
        resetn = 1'b1;
        tick(20);
        check_eq("arst_no_valid", n_dval - s_dval, 0);
        rd_value = 16'h1357;
        snap();
        disp_request(22'h2AAAAA);
        tick(20);
        check_eq("arst_next_data", disp_data, 16'h1357);
        check_eq("arst_next_valid", n_dval - s_dval, 1);
        check_eq("arst_next_addr", last_addr, 22'h2AAAAA);
        check_eq("final_strobe_spacing", n_back2back, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_request_scheduler.md
Name: vram_request_scheduler

Overview:
- Initiator side of the VRAM memory-controller request interface (read/write/refresh/addr/din/wdm in, dout/busy out of the controller).
- Arbitrates two clients onto the single controller port:
  - display fetch: read-only, highest client priority;
  - CPU port: read/write, with starvation guard.
- Generates periodic auto-refresh, issues one-cycle request pulses only while the controller is idle, and returns read data to the requesting client.

Parameters:
- FREQ, 54_000_000, system clock frequency in Hz (documentation/derivation only).
- REFRESH_CYCLES, 420, clk cycles between refresh ticks (7.8 us at 54 MHz).
- STARVE_LIMIT, 4, consecutive display grants while cpu_req is pending before the CPU is forced ahead of display.

Ports:
- clk, in, 1, main logic clock
- resetn, in, 1, asynchronous active-low reset
- disp_req, in, 1, display read request; held until disp_ack
- disp_addr, in, 22, display word address
- disp_ack, out, 1, one-cycle pulse: request accepted
- disp_data, out, 16, display read data
- disp_valid, out, 1, one-cycle pulse: disp_data valid
- cpu_req, in, 1, CPU request; held until cpu_ack
- cpu_we, in, 1, 1 = write, 0 = read
- cpu_addr, in, 22, CPU word address
- cpu_din, in, 16, CPU write data
- cpu_wdm, in, 2, CPU write byte masks
- cpu_ack, out, 1, one-cycle pulse: request accepted
- cpu_dout, out, 16, CPU read data
- cpu_valid, out, 1, one-cycle pulse: cpu_dout valid (reads only)
- mc_read, out, 1, controller read strobe
- mc_write, out, 1, controller write strobe
- mc_refresh, out, 1, controller refresh strobe
- mc_addr, out, 22, controller address
- mc_din, out, 16, controller write data
- mc_wdm, out, 2, controller byte masks
- mc_dout, in, 16, controller read data (held after completion)
- mc_busy, in, 1, controller busy; high during init and each operation
- refresh_overrun, out, 1, sticky: a refresh tick was lost

Behaviour:
- Reset (async, resetn=0):
  - FSM enters IDLE.
  - All strobes, acks, valids and refresh_overrun clear to 0.
  - mc_addr, mc_din, mc_wdm, disp_data and cpu_dout clear to 0.
  - Refresh timer and pending count clear to 0; starve counter clears to 0.
  - Assertion mid-operation abandons the operation; no valid is generated for it.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1, then wraps; each wrap is one tick.
  - Runs continuously, including while mc_busy is high during controller init.
- Refresh pending count (2-bit):
  - Increments on tick and decrements on refresh issue; tick and issue in the same cycle leave it unchanged.
  - Tick at count 3 with no issue: count stays 3 and refresh_overrun sets (sticky until reset).
- FSM states:
  - IDLE: with mc_busy=0, choose a winner; if none, stay. Priority:
    1. refresh, if pending > 0;
    2. CPU, if cpu_req and starve counter == STARVE_LIMIT;
    3. display, if disp_req;
    4. CPU, if cpu_req.
  - IDLE, on a grant:
    - Register the strobe (exactly one of mc_read/mc_write/mc_refresh) together with mc_addr/mc_din/mc_wdm; strobe is visible next cycle for exactly one cycle.
    - Pulse the matching client ack in that same cycle; refresh has no ack.
    - Go to ISSUE.
  - ISSUE: strobe high; go to WAIT_BUSY.
  - WAIT_BUSY: on mc_busy=1 go to WAIT_DONE. If mc_busy is still 0 after 2 cycles, the controller missed the strobe: re-issue the identical strobe once via ISSUE.
  - WAIT_DONE: on mc_busy=0:
    - read op: register mc_dout into disp_data or cpu_dout, pulse the matching valid next cycle;
    - in all cases return to IDLE.
  - Requests are never issued while mc_busy=1.
- Starve counter:
  - Increments on each display grant while cpu_req=1.
  - Resets to 0 on any CPU grant or when cpu_req=0; saturates at STARVE_LIMIT.
- Issue timing:
  - Grant cycle T: ack pulses at T, strobe at T+1.
  - Back-to-back operations are separated by at least one IDLE cycle.
  - Read valid arrives no earlier than the cycle after the busy falling edge.
- Client handshake:
  - Address/data are sampled only in the grant cycle.
  - A client may change its fields or drop req after ack.
  - Dropping req before ack withdraws the request without side effect.
- Other rules:
  - disp_data and cpu_dout hold their last value between valids.
  - CPU writes produce no cpu_valid.

Test Plan:
- Reset release with mc_busy=1 for 100 cycles, disp_req held → no strobe before mc_busy falls; mc_read with disp_addr 1 cycle after the first IDLE grant; disp_ack exactly once.
- Display read addr 0x000123, controller model returns 0xBEEF (busy 4 cycles) → disp_valid single pulse with disp_data=0xBEEF; cpu_valid stays 0.
- cpu_req write addr 0x3FFFFF, din 0x1234, wdm 2'b01 → single mc_write pulse with those values; cpu_ack once; no cpu_valid.
- disp_req and cpu_req held continuously → grant sequence D,D,D,D,C,D,D,D,D,C (STARVE_LIMIT=4).
- REFRESH_CYCLES=8, mc_busy held high 40 cycles → pending saturates at 3, refresh_overrun=1; after busy drops, 3 consecutive mc_refresh ops issue before any client grant.
- Async reset mid-read (WAIT_DONE) → all outputs 0 immediately; no disp_valid after release; next request serviced normally.
